digit_overlay: RTL

DIGIT_OVERLAY -- requirements
Module: digit_overlay

---
 rtl/digit_overlay.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/digit_overlay.sv
// Seven-segment style BCD digit overlay drawn from h/v sync-derived pixel counters.
// Optional colon slots between digit pairs are enabled by defining DIGIT_OVERLAY_COLON_EN.
module digit_overlay #(
   parameter int NDIG       = 6,
   parameter int X0         = 343,
   parameter int Y0         = 235,
   parameter int GAP        = 3,
   parameter int SCALE_LOG2 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              h_sinc,
   input  logic              v_sinc,
   input  logic [4*NDIG-1:0] digits,
   input  logic [2:0]        fg_rgb,
   output logic [2:0]        rgb,
   output logic              pix_on
);

   localparam int         CELL    = 1 << SCALE_LOG2;
   localparam int         PITCH   = 5 + GAP;
   localparam logic [10:0] CNT_MAX = 11'h7FF;

   logic              h_prev, v_prev;
   logic              h_fall, v_fall;
   logic [10:0]       count_h, count_v;
   logic [4*NDIG-1:0] shadow;
   logic              frame_valid;
   logic              lit;
   logic              show;

   assign h_fall = h_prev & ~h_sinc;
   assign v_fall = v_prev & ~v_sinc;

   // frame_valid keeps the overlay dark between reset and the first frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_prev      <= 1'b1;
         v_prev      <= 1'b1;
         count_h     <= '0;
         count_v     <= '0;
         shadow      <= '1;
         frame_valid <= 1'b0;
      end else begin
         h_prev <= h_sinc;
         v_prev <= v_sinc;
         if (h_fall)
            count_h <= '0;
         else if (count_h != CNT_MAX)
            count_h <= count_h + 11'd1;
         if (v_fall)
            count_v <= '0;
         else if (h_fall && count_v != CNT_MAX)
            count_v <= count_v + 11'd1;
         if (v_fall) begin
            shadow      <= digits;
            frame_valid <= 1'b1;
         end
      end
   end

   // Segment order {g,f,e,d,c,b,a}; non-decimal codes render blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg_decode = 7'b0111111;
         4'd1:    seg_decode = 7'b0000110;
         4'd2:    seg_decode = 7'b1011011;
         4'd3:    seg_decode = 7'b1001111;
         4'd4:    seg_decode = 7'b1100110;
         4'd5:    seg_decode = 7'b1101101;
         4'd6:    seg_decode = 7'b1111101;
         4'd7:    seg_decode = 7'b0000111;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1101111;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   function automatic logic glyph_cell(input logic [6:0] seg, input int row, input int col);
      glyph_cell = 1'b0;
      if (row == 0 && col >= 1 && col <= 3)
         glyph_cell = seg[0];
      else if (row >= 1 && row <= 3 && col == 0)
         glyph_cell = seg[5];
      else if (row >= 1 && row <= 3 && col == 4)
         glyph_cell = seg[1];
      else if (row == 4 && col >= 1 && col <= 3)
         glyph_cell = seg[6];
      else if (row >= 5 && row <= 7 && col == 0)
         glyph_cell = seg[4];
      else if (row >= 5 && row <= 7 && col == 4)
         glyph_cell = seg[2];
      else if (row == 8 && col >= 1 && col <= 3)
         glyph_cell = seg[3];
   endfunction

   function automatic int slot_left(input int i);
`ifdef DIGIT_OVERLAY_COLON_EN
      slot_left = X0 + (i * PITCH + (i >> 1) * (1 + GAP)) * CELL;
`else
      slot_left = X0 + i * PITCH * CELL;
`endif
   endfunction

   // Slots past the 11-bit counter range simply never match, so they clip cleanly.
   always_comb begin : render
      int  h_pos, v_pos, row, rel;
      logic in_rows;
      lit     = 1'b0;
      h_pos   = int'(count_h);
      v_pos   = int'(count_v);
      row     = (v_pos - Y0) >>> SCALE_LOG2;
      in_rows = (v_pos >= Y0) && (v_pos < Y0 + 9 * CELL);
      rel     = 0;
      for (int i = 0; i < NDIG; i++) begin
         rel = h_pos - slot_left(i);
         if (in_rows && rel >= 0 && rel < 5 * CELL)
            lit = lit | glyph_cell(seg_decode(shadow[4*(NDIG-1-i) +: 4]), row, rel >>> SCALE_LOG2);
      end
`ifdef DIGIT_OVERLAY_COLON_EN
      for (int k = 0; 2 * k + 1 < NDIG - 1; k++) begin
         rel = h_pos - (slot_left(2 * k + 1) + PITCH * CELL);
         if (in_rows && rel >= 0 && rel < CELL && (row == 2 || row == 6))
            lit = 1'b1;
      end
`endif
   end

   assign show = lit & frame_valid & (count_h != CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_on <= 1'b0;
         rgb    <= 3'b000;
      end else begin
         pix_on <= show;
         rgb    <= show ? fg_rgb : 3'b000;
      end
   end

endmodule
